// File: rtl/modn_updown_counter.sv
// Parametrised mod-N up/down counter with clamped load, terminal count and a registered wrap pulse.
// Define MODN_CNT_SAT_EN to saturate at 0 / MODULUS-1 instead of wrapping (wrap then stays low).
module modn_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             set,
  input  logic [WIDTH-1:0] set_num,
  output logic [WIDTH-1:0] number,
  output logic             zero,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS = 2**WIDTH compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] number_q, number_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min, in_range, load_clamp;

  assign at_max     = (number_q == MAX_VAL);
  assign at_min     = (number_q == '0);
  assign in_range   = ({1'b0, number_q} < MOD_EXT);
  assign load_clamp = ({1'b0, set_num} >= MOD_EXT);

  // Next-count and wrap-pulse logic; reset is applied in the register stage.
  always_comb begin
    number_d = number_q;
    wrap_d   = 1'b0;
    if (set) begin
      number_d = load_clamp ? MAX_VAL : set_num;
    end else if (en) begin
      if (!in_range) begin
        number_d = '0;
      end else if (up) begin
        if (at_max) begin
`ifdef MODN_CNT_SAT_EN
          number_d = MAX_VAL;
`else
          number_d = '0;
          wrap_d   = 1'b1;
`endif
        end else begin
          number_d = number_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
`ifdef MODN_CNT_SAT_EN
          number_d = '0;
`else
          number_d = MAX_VAL;
          wrap_d   = 1'b1;
`endif
        end else begin
          number_d = number_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      number_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      number_q <= number_d;
      wrap_q   <= wrap_d;
    end
  end

  assign number = number_q;
  assign wrap   = wrap_q;
  assign zero   = at_min;
  assign tc     = up ? at_max : at_min;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench for modn_updown_counter: a MODULUS=10 and a MODULUS=16 instance share stimulus,
// each checked against an arithmetic reference model through its own expected-response queue.
module tb_modn_updown_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned M_A = 10;
  localparam int unsigned M_B = 16;

  typedef struct packed {
    logic [W-1:0] number;
    logic         zero;
    logic         tc;
    logic         wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         up  = 1'b1;
  logic         set = 1'b0;
  logic [W-1:0] set_num = '0;

  logic [W-1:0] num_a, num_b;
  logic         zero_a, tc_a, wrap_a, zero_b, tc_b, wrap_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   st_a = 0;
  int   st_b = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(W), .MODULUS(M_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .set(set), .set_num(set_num),
    .number(num_a), .zero(zero_a), .tc(tc_a), .wrap(wrap_a)
  );

  modn_updown_counter #(.WIDTH(W), .MODULUS(M_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .set(set), .set_num(set_num),
    .number(num_b), .zero(zero_b), .tc(tc_b), .wrap(wrap_b)
  );

  // Reference: the count after the coming edge, from the priority rules in plain integer arithmetic.
  function automatic exp_t model(input int m, input int n);
    int   nn;
    bit   w;
    exp_t e;
    w = 1'b0;
    if (rst) nn = 0;
    else if (set) nn = (int'(set_num) >= m) ? m - 1 : int'(set_num);
    else if (en) begin
`ifdef MODN_CNT_SAT_EN
      nn = up ? ((n + 1 > m - 1) ? m - 1 : n + 1) : ((n - 1 < 0) ? 0 : n - 1);
`else
      nn = up ? (n + 1) % m : (n + m - 1) % m;
      w  = up ? (n == m - 1) : (n == 0);
`endif
    end else nn = n;
    e.number = W'(nn);
    e.zero   = (nn == 0);
    e.tc     = up ? (nn == m - 1) : (nn == 0);
    e.wrap   = w;
    return e;
  endfunction

  task automatic step(input bit r, input bit s, input bit e, input bit u, input int v);
    exp_t ea, eb;
    @(negedge clk);
    rst = r; set = s; en = e; up = u; set_num = W'(v);
    ea = model(int'(M_A), st_a);
    eb = model(int'(M_B), st_b);
    st_a = int'(ea.number);
    st_b = int'(eb.number);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic cmp(input string name, input logic [W-1:0] n, input logic z, input logic t,
                     input logic w, input exp_t e);
    checks += 4;
    if (n !== e.number) begin
      errors++;
      $display("FAIL %s.number @%0t: got %0d expected %0d", name, $time, n, e.number);
    end
    if (z !== e.zero) begin
      errors++;
      $display("FAIL %s.zero @%0t: got %b expected %b", name, $time, z, e.zero);
    end
    if (t !== e.tc) begin
      errors++;
      $display("FAIL %s.tc @%0t: got %b expected %b", name, $time, t, e.tc);
    end
    if (w !== e.wrap) begin
      errors++;
      $display("FAIL %s.wrap @%0t: got %b expected %b", name, $time, w, e.wrap);
    end
  endtask

  // Monitor: the count is presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp("mod10", num_a, zero_a, tc_a, wrap_a, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp("mod16", num_b, zero_b, tc_b, wrap_b, e);
      end
    end
  end

  initial begin
    int guard;
    // Reset, then count up through the wrap.
    repeat (2) step(1, 0, 0, 1, 0);
    repeat (12) step(0, 0, 1, 1, 0);
    // Count down through 0 -> MODULUS-1.
    step(1, 0, 0, 0, 0);
    repeat (11) step(0, 0, 1, 0, 0);
    // Load, clamp, load with enable low.
    step(0, 1, 0, 1, 5);
    step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 13);
    step(0, 1, 0, 0, 7);
    // Priority: reset over load, load over count at the top, hold.
    step(1, 1, 1, 1, 5);
    step(0, 1, 0, 1, 9);
    step(0, 1, 1, 1, 9);
    repeat (4) step(0, 0, 0, 1, 0);
    // Reset mid-count at 7, then resume.
    step(1, 0, 0, 1, 0);
    repeat (7) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    // Top of a full 2**WIDTH range: 14 -> 15 -> wrap or saturate, then down.
    step(0, 1, 0, 1, 14);
    repeat (3) step(0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
    end
    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
